// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH   = 12;
  localparam int unsigned PWM_TIMEOUT = 8191;
  localparam int unsigned PWM_IDLE_W  = $clog2(PWM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StWaitRise,
    StHigh,
    StLow
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with registered rise/fall strobes.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= s;
      rise   <= s & ~s_d;
      fall   <= ~s & s_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: high time and rise-to-rise period in clk cycles,
// with saturation and stuck-input detection.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] pw_out,
  output logic [WIDTH:0]   period_out,
  output logic             valid,
  output logic             overflow,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] HiMax   = '1;
  localparam logic [WIDTH:0]   PerMax  = '1;
  localparam logic [IdleW-1:0] IdleMax = '1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  logic             s, rise, fall;
  pwm_state_e       state_q;
  logic [WIDTH-1:0] hi_q, hi_inc;
  logic [WIDTH:0]   per_q, per_inc;
  logic [IdleW-1:0] idle_q, idle_inc;
  logic             edge_seen, timeout;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    hi_inc    = (hi_q == HiMax) ? hi_q : hi_q + 1'b1;
    per_inc   = (per_q == PerMax) ? per_q : per_q + 1'b1;
    idle_inc  = (idle_q == IdleMax) ? idle_q : idle_q + 1'b1;
    edge_seen = rise | fall;
    // An edge landing on the timeout cycle takes priority.
    timeout   = ~edge_seen & (idle_q >= IdleLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitRise;
      hi_q       <= '0;
      per_q      <= '0;
      idle_q     <= '0;
      pw_out     <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else if (!enable) begin
      state_q    <= StWaitRise;
      hi_q       <= '0;
      per_q      <= '0;
      idle_q     <= '0;
      valid      <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (edge_seen) begin
        idle_q     <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else begin
        idle_q <= idle_inc;
      end

      if (timeout) begin
        state_q    <= StWaitRise;
        hi_q       <= '0;
        per_q      <= '0;
        stuck_high <= s;
        stuck_low  <= ~s;
      end else begin
        unique case (state_q)
          StWaitRise: begin
            if (rise) begin
              state_q <= StHigh;
              hi_q    <= WIDTH'(1);
              per_q   <= (WIDTH + 1)'(1);
            end else begin
              hi_q  <= '0;
              per_q <= '0;
            end
          end
          StHigh: begin
            per_q <= per_inc;
            if (fall) state_q <= StLow;
            else      hi_q    <= hi_inc;
          end
          StLow: begin
            if (rise) begin
              pw_out     <= hi_q;
              period_out <= per_q;
              overflow   <= (hi_q == HiMax) | (per_q == PerMax);
              valid      <= 1'b1;
              state_q    <= StHigh;
              hi_q       <= WIDTH'(1);
              per_q      <= (WIDTH + 1)'(1);
            end else begin
              per_q <= per_inc;
            end
          end
          default: state_q <= StWaitRise;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: widths, periods, latency, saturation, timeouts, enable, reset.
module tb_pwm_capture;

  localparam int unsigned Width = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             pwm_in = 1'b0;
  logic [Width-1:0] pw_out;
  logic [Width:0]   period_out;
  logic             valid, overflow, stuck_high, stuck_low;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int base;
  int lat;

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_cnt <= valid_cnt + 1;

  pwm_capture #(
    .WIDTH      (Width),
    .SYNC_STAGES(2),
    .TIMEOUT    (8191)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .pw_out    (pw_out),
    .period_out(period_out),
    .valid     (valid),
    .overflow  (overflow),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pulses(input int hi, input int lo, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(lo);
    end
  endtask

  initial begin
    tick(3);
    chk("reset_pw", 32'(pw_out), 0);
    chk("reset_flags", {28'd0, valid, overflow, stuck_high, stuck_low}, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(2);

    // 10 high / 30 low
    base = valid_cnt;
    drive_pulses(10, 30, 3);
    chk("p10_valid_cnt", 32'(valid_cnt - base), 2);
    chk("p10_pw", 32'(pw_out), 10);
    chk("p10_period", 32'(period_out), 40);
    chk("p10_ovf", 32'(overflow), 0);

    // rise-to-valid latency: SYNC_STAGES+2 edges
    pwm_in = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!valid && lat < 20);
    chk("latency", 32'(lat), 4);
    tick(10 - lat);
    pwm_in = 1'b0;
    tick(30);

    // 1 high / 1 low
    drive_pulses(1, 1, 6);
    tick(10);
    chk("p1_pw", 32'(pw_out), 1);
    chk("p1_period", 32'(period_out), 2);

    // enable low clears the engine but holds published values
    enable = 1'b0;
    tick(3);
    chk("dis_hold_pw", 32'(pw_out), 1);
    chk("dis_hold_period", 32'(period_out), 2);
    chk("dis_valid", 32'(valid), 0);
    enable = 1'b1;
    tick(2);

    // 25 high in a 4096-cycle frame
    base = valid_cnt;
    drive_pulses(25, 4071, 3);
    chk("frame_valid_cnt", 32'(valid_cnt - base), 2);
    chk("frame_pw", 32'(pw_out), 25);
    chk("frame_period", 32'(period_out), 4096);
    chk("frame_ovf", 32'(overflow), 0);

    // stuck low: timeout visible 4+8191 edges after the falling transition
    pwm_in = 1'b1;
    tick(20);
    pwm_in = 1'b0;
    base = valid_cnt;
    tick(8194);
    chk("stuck_low_early", 32'(stuck_low), 0);
    tick(1);
    chk("stuck_low_set", 32'(stuck_low), 1);
    chk("stuck_low_sh", 32'(stuck_high), 0);
    chk("stuck_low_pw", 32'(pw_out), 25);
    chk("stuck_low_novalid", 32'(valid_cnt - base), 0);
    pwm_in = 1'b1;
    tick(10);
    chk("stuck_low_clr", 32'(stuck_low), 0);
    pwm_in = 1'b0;
    tick(30);
    base = valid_cnt;
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    chk("post_stuck_valid_cnt", 32'(valid_cnt - base), 1);
    chk("post_stuck_pw", 32'(pw_out), 10);
    chk("post_stuck_period", 32'(period_out), 40);

    // stuck high
    pwm_in = 1'b1;
    tick(8194);
    chk("stuck_high_early", 32'(stuck_high), 0);
    tick(1);
    chk("stuck_high_set", 32'(stuck_high), 1);
    chk("stuck_high_sl", 32'(stuck_low), 0);
    pwm_in = 1'b0;
    tick(10);
    chk("stuck_high_clr", 32'(stuck_high), 0);

    // high time saturates at 4095
    base = valid_cnt;
    drive_pulses(4100, 100, 2);
    chk("sat_valid_cnt", 32'(valid_cnt - base), 1);
    chk("sat_pw", 32'(pw_out), 4095);
    chk("sat_period", 32'(period_out), 4200);
    chk("sat_ovf", 32'(overflow), 1);
    drive_pulses(10, 30, 3);
    chk("unsat_ovf", 32'(overflow), 0);
    chk("unsat_pw", 32'(pw_out), 10);

    // enable dropped mid-HIGH
    pwm_in = 1'b1;
    tick(6);
    base = valid_cnt;
    tick(2);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(30);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    chk("en_novalid", 32'(valid_cnt - base), 0);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    chk("en_valid_cnt", 32'(valid_cnt - base), 1);
    chk("en_pw", 32'(pw_out), 10);
    chk("en_period", 32'(period_out), 40);

    // asynchronous reset mid-LOW
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pw", 32'(pw_out), 0);
    chk("arst_period", 32'(period_out), 0);
    chk("arst_flags", {28'd0, valid, overflow, stuck_high, stuck_low}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base = valid_cnt;
    drive_pulses(10, 30, 2);
    chk("arst_valid_cnt", 32'(valid_cnt - base), 1);
    chk("arst_new_pw", 32'(pw_out), 10);
    chk("arst_new_period", 32'(period_out), 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
